// File: rtl/score_round_ctrl_if.sv
// Round-controller bundle: press/hit inputs toward the controller, score/time/state toward the display.
// Latency: none, wires only.
// Backpressure: none; all events are single-cycle pulses.
interface score_round_ctrl_if;
    logic        btn_pulse;
    logic        hit;
    logic [3:0]  hit_points;
    logic [15:0] score_bcd;
    logic [15:0] high_bcd;
    logic [7:0]  time_left_bcd;
    logic [1:0]  state;
    logic        new_high;

    modport master (
        output btn_pulse, hit, hit_points,
        input  score_bcd, high_bcd, time_left_bcd, state, new_high
    );

    modport slave (
        input  btn_pulse, hit, hit_points,
        output score_bcd, high_bcd, time_left_bcd, state, new_high
    );
endinterface

// File: rtl/score_round_ctrl.sv
// Round FSM with BCD countdown, saturating BCD score and retained high score.
// Latency: every input takes effect on the sampling edge; high score follows DONE entry by one edge.
// Backpressure: none; each press/hit pulse is consumed in the cycle it arrives.
module score_round_ctrl #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int ROUND_SECONDS = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    score_round_ctrl_if.slave io
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int              TW        = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [7:0]      ROUND_BCD = {4'(ROUND_SECONDS / 10), 4'(ROUND_SECONDS % 10)};

    state_t        state_q, state_d;
    logic [15:0]   score_q, score_d;
    logic [15:0]   high_q, high_d;
    logic [7:0]    time_q, time_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          new_high_q, new_high_d;
    logic          eval_q, eval_d;
    logic          tick_wrap;

    // Digit-wise BCD add of a clamped single-digit value; a carry out of the MSD saturates.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [3:0] p);
        logic [15:0] r;
        logic [4:0]  s;
        logic [3:0]  c;
        c = (p > 4'd9) ? 4'd9 : p;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, a[i*4 +: 4]} + {1'b0, c};
            if (s > 5'd9) begin
                r[i*4 +: 4] = 4'(s - 5'd10);
                c = 4'd1;
            end else begin
                r[i*4 +: 4] = s[3:0];
                c = 4'd0;
            end
        end
        if (c != 4'd0) begin
            r = 16'h9999;
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] t);
        logic [7:0] r;
        if (t[3:0] == 4'd0) begin
            r = {t[7:4] - 4'd1, 4'd9};
        end else begin
            r = {t[7:4], t[3:0] - 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        time_d     = time_q;
        tick_d     = tick_q;
        new_high_d = 1'b0;
        eval_d     = 1'b0;
        tick_wrap  = (tick_q == TICK_LAST);

        case (state_q)
            ST_IDLE: begin
                if (io.btn_pulse) begin
                    state_d = ST_RUN;
                    score_d = '0;
                    time_d  = ROUND_BCD;
                    tick_d  = '0;
                end
            end
            ST_RUN: begin
                tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                // The hit counts even on the cycle RUN is left, by abort or by time-out.
                if (io.hit) begin
                    score_d = bcd_add_sat(score_q, io.hit_points);
                end
                if (io.btn_pulse) begin
                    state_d = ST_DONE;
                    eval_d  = 1'b1;
                end else if (tick_wrap) begin
                    if (time_q == 8'h01) begin
                        time_d  = 8'h00;
                        state_d = ST_DONE;
                        eval_d  = 1'b1;
                    end else begin
                        time_d = bcd_dec(time_q);
                    end
                end
            end
            ST_DONE: begin
                if (io.btn_pulse) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Packed BCD orders the same as its binary value, so a plain compare is numeric.
        if (eval_q && (score_q > high_q)) begin
            high_d     = score_q;
            new_high_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            score_q    <= '0;
            high_q     <= '0;
            time_q     <= '0;
            tick_q     <= '0;
            new_high_q <= 1'b0;
            eval_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            time_q     <= time_d;
            tick_q     <= tick_d;
            new_high_q <= new_high_d;
            eval_q     <= eval_d;
        end
    end

    assign io.score_bcd     = score_q;
    assign io.high_bcd      = high_q;
    assign io.time_left_bcd = time_q;
    assign io.state         = state_q;
    assign io.new_high      = new_high_q;

endmodule

// File: tb/tb_score_round_ctrl.sv
// Bench for score_round_ctrl: small-round instance (4 ticks/s, 3 s) plus a long-round instance for saturation.
module tb_score_round_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    score_round_ctrl_if ifa ();
    score_round_ctrl_if ifb ();

    score_round_ctrl #(.TICKS_PER_SEC(4), .ROUND_SECONDS(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifa.slave)
    );

    score_round_ctrl #(.TICKS_PER_SEC(2000), .ROUND_SECONDS(99)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifb.slave)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic [7:0]  tl;
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_a();
        ifa.btn_pulse = 1'b1;
        tick();
        ifa.btn_pulse = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int k;
        k = 0;
        while (ifa.state !== 2'd2 && k < 40) begin
            tick();
            k++;
        end
        n_checks++;
        if (ifa.state !== 2'd2) begin
            n_fail++;
            $display("FAIL %s: state=%0d required=2 within 40 cycles", tag, ifa.state);
        end
    endtask

    task automatic hits_a(input int n, input logic [3:0] pts[4], input logic [15:0] exp_sc[4], input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            ifa.hit = 1'b1;
            ifa.hit_points = pts[i];
            exp_q.push_back('{st: 2'd1, tl: 8'h00, sc: exp_sc[i]});
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (ifa.score_bcd !== e.sc) begin
                n_fail++;
                $display("FAIL %s[%0d] score: got %h required %h", tag, i, ifa.score_bcd, e.sc);
            end
        end
        ifa.hit = 1'b0;
        ifa.hit_points = 4'd0;
    endtask

    task automatic test_reset();
        ifa.btn_pulse = 0; ifa.hit = 0; ifa.hit_points = 0;
        ifb.btn_pulse = 0; ifb.hit = 0; ifb.hit_points = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++; if (ifa.state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d required 0", ifa.state); end
        n_checks++; if (ifa.score_bcd !== 16'h0000) begin n_fail++; $display("FAIL rst_score: got %h required 0000", ifa.score_bcd); end
        n_checks++; if (ifa.high_bcd !== 16'h0000) begin n_fail++; $display("FAIL rst_high: got %h required 0000", ifa.high_bcd); end
        n_checks++; if (ifa.time_left_bcd !== 8'h00) begin n_fail++; $display("FAIL rst_time: got %h required 00", ifa.time_left_bcd); end
        n_checks++; if (ifa.new_high !== 1'b0) begin n_fail++; $display("FAIL rst_new_high: got %b required 0", ifa.new_high); end
        #2 rst_n = 1'b1;
        tick();
        tick();
        n_checks++; if (ifa.state !== 2'd0) begin n_fail++; $display("FAIL idle_hold: got %0d required 0", ifa.state); end
    endtask

    task automatic test_start_countdown();
        exp_t e;
        logic [7:0] tl;
        press_a();
        n_checks++; if (ifa.state !== 2'd1) begin n_fail++; $display("FAIL start_state: got %0d required 1", ifa.state); end
        n_checks++; if (ifa.time_left_bcd !== 8'h03) begin n_fail++; $display("FAIL start_time: got %h required 03", ifa.time_left_bcd); end
        n_checks++; if (ifa.score_bcd !== 16'h0000) begin n_fail++; $display("FAIL start_score: got %h required 0000", ifa.score_bcd); end
        for (int k = 1; k <= 12; k++) begin
            tl = (k < 4) ? 8'h03 : (k < 8) ? 8'h02 : (k < 12) ? 8'h01 : 8'h00;
            exp_q.push_back('{st: (k == 12) ? 2'd2 : 2'd1, tl: tl, sc: 16'h0000});
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (ifa.state !== e.st || ifa.time_left_bcd !== e.tl) begin
                n_fail++;
                $display("FAIL countdown[%0d]: state=%0d time=%h required state=%0d time=%h",
                         k, ifa.state, ifa.time_left_bcd, e.st, e.tl);
            end
        end
        tick();
        n_checks++; if (ifa.new_high !== 1'b0) begin n_fail++; $display("FAIL zero_round_new_high: got %b required 0", ifa.new_high); end
        press_a();
        n_checks++; if (ifa.state !== 2'd0) begin n_fail++; $display("FAIL done_to_idle: got %0d required 0", ifa.state); end
    endtask

    task automatic test_bcd_scoring();
        logic [3:0]  pts[4];
        logic [15:0] sc[4];
        exp_t e;
        pts = '{4'd7, 4'd5, 4'd9, 4'd12};
        sc  = '{16'h0007, 16'h0012, 16'h0021, 16'h0030};
        press_a();
        hits_a(4, pts, sc, "score");
        wait_done_a("r1_done");
        n_checks++; if (ifa.high_bcd !== 16'h0000 || ifa.new_high !== 1'b0) begin n_fail++; $display("FAIL r1_early_high: high=%h new_high=%b required 0000/0", ifa.high_bcd, ifa.new_high); end
        tick();
        n_checks++; if (ifa.high_bcd !== 16'h0030 || ifa.new_high !== 1'b1) begin n_fail++; $display("FAIL r1_high: high=%h new_high=%b required 0030/1", ifa.high_bcd, ifa.new_high); end
        tick();
        n_checks++; if (ifa.new_high !== 1'b0) begin n_fail++; $display("FAIL r1_pulse_width: new_high=%b required 0", ifa.new_high); end
        press_a();
        ifa.hit = 1'b1;
        ifa.hit_points = 4'd9;
        exp_q.push_back('{st: 2'd0, tl: 8'h00, sc: 16'h0030});
        tick();
        ifa.hit = 1'b0;
        e = exp_q.pop_front();
        n_checks++; if (ifa.score_bcd !== e.sc || ifa.state !== e.st) begin n_fail++; $display("FAIL idle_hit: score=%h state=%0d required %h/%0d", ifa.score_bcd, ifa.state, e.sc, e.st); end
    endtask

    task automatic test_high_equal();
        logic [3:0]  pts[4];
        logic [15:0] sc[4];
        pts = '{4'd9, 4'd9, 4'd9, 4'd3};
        sc  = '{16'h0009, 16'h0018, 16'h0027, 16'h0030};
        press_a();
        hits_a(4, pts, sc, "r2");
        wait_done_a("r2_done");
        tick();
        n_checks++; if (ifa.high_bcd !== 16'h0030 || ifa.new_high !== 1'b0) begin n_fail++; $display("FAIL r2_equal: high=%h new_high=%b required 0030/0", ifa.high_bcd, ifa.new_high); end
        tick();
        n_checks++; if (ifa.new_high !== 1'b0) begin n_fail++; $display("FAIL r2_late_pulse: new_high=%b required 0", ifa.new_high); end
        press_a();
    endtask

    task automatic test_abort_hit();
        logic [3:0]  pts[4];
        logic [15:0] sc[4];
        exp_t e;
        int k;
        pts = '{4'd9, 4'd9, 4'd9, 4'd0};
        sc  = '{16'h0009, 16'h0018, 16'h0027, 16'h0027};
        press_a();
        hits_a(3, pts, sc, "r3");
        k = 0;
        while (ifa.time_left_bcd !== 8'h02 && k < 10) begin
            tick();
            k++;
        end
        n_checks++; if (ifa.time_left_bcd !== 8'h02 || ifa.state !== 2'd1) begin n_fail++; $display("FAIL r3_reach_02: time=%h state=%0d required 02/1", ifa.time_left_bcd, ifa.state); end
        ifa.btn_pulse = 1'b1;
        ifa.hit = 1'b1;
        ifa.hit_points = 4'd4;
        exp_q.push_back('{st: 2'd2, tl: 8'h02, sc: 16'h0031});
        tick();
        ifa.btn_pulse = 1'b0;
        ifa.hit = 1'b0;
        e = exp_q.pop_front();
        n_checks++; if (ifa.score_bcd !== e.sc) begin n_fail++; $display("FAIL abort_score: got %h required %h", ifa.score_bcd, e.sc); end
        n_checks++; if (ifa.state !== e.st) begin n_fail++; $display("FAIL abort_state: got %0d required %0d", ifa.state, e.st); end
        n_checks++; if (ifa.time_left_bcd !== e.tl) begin n_fail++; $display("FAIL abort_time: got %h required %h", ifa.time_left_bcd, e.tl); end
        tick();
        n_checks++; if (ifa.high_bcd !== 16'h0031 || ifa.new_high !== 1'b1) begin n_fail++; $display("FAIL abort_high: high=%h new_high=%b required 0031/1", ifa.high_bcd, ifa.new_high); end
        press_a();
        n_checks++; if (ifa.state !== 2'd0) begin n_fail++; $display("FAIL abort_to_idle: got %0d required 0", ifa.state); end
    endtask

    task automatic test_saturation();
        exp_t e;
        int   model;
        logic [3:0] p;
        ifb.btn_pulse = 1'b1;
        tick();
        ifb.btn_pulse = 1'b0;
        n_checks++; if (ifb.state !== 2'd1) begin n_fail++; $display("FAIL sat_start: got %0d required 1", ifb.state); end
        model = 0;
        for (int i = 0; i < 1116; i++) begin
            if (i < 1111) p = (i % 5 == 0) ? 4'd15 : 4'd9;
            else if (i == 1112) p = 4'd0;
            else p = 4'd7;
            model = model + ((p > 4'd9) ? 9 : int'(p));
            if (model > 9999) model = 9999;
            ifb.hit = 1'b1;
            ifb.hit_points = p;
            exp_q.push_back('{st: 2'd1, tl: 8'h00, sc: to_bcd(model)});
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (ifb.score_bcd !== e.sc) begin
                n_fail++;
                $display("FAIL sat[%0d]: got %h required %h", i, ifb.score_bcd, e.sc);
            end
        end
        ifb.hit = 1'b0;
        n_checks++; if (ifb.score_bcd !== 16'h9999) begin n_fail++; $display("FAIL sat_final: got %h required 9999", ifb.score_bcd); end
    endtask

    task automatic test_reset_mid_round();
        press_a();
        tick();
        tick();
        n_checks++; if (ifa.state !== 2'd1 || ifa.high_bcd !== 16'h0031) begin n_fail++; $display("FAIL pre_reset: state=%0d high=%h required 1/0031", ifa.state, ifa.high_bcd); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (ifa.state !== 2'd0) begin n_fail++; $display("FAIL async_state: got %0d required 0", ifa.state); end
        n_checks++; if (ifa.high_bcd !== 16'h0000) begin n_fail++; $display("FAIL async_high: got %h required 0000", ifa.high_bcd); end
        n_checks++; if (ifa.score_bcd !== 16'h0000 || ifa.time_left_bcd !== 8'h00 || ifa.new_high !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rest: score=%h time=%h new_high=%b required 0000/00/0", ifa.score_bcd, ifa.time_left_bcd, ifa.new_high);
        end
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start_countdown();
        test_bcd_scoring();
        test_high_equal();
        test_abort_hit();
        test_saturation();
        test_reset_mid_round();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
